// File: rtl/mmu_pkg.sv
// Shared types and helpers for the systolic operand feeder and its lane muxes.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package mmu_pkg;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_LENGTH        = 3;
    localparam int ACCUMULATOR_WIDTH = 2 * DEF_WIDTH + $clog2(DEF_LENGTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } feeder_state_t;

    // k is the reduction index a lane presents at a given step; vld is low
    // while the lane sits in the zero-padded part of its skew.
    typedef struct packed {
        logic        vld;
        logic [31:0] k;
    } skew_t;

    function automatic skew_t skew_idx(input int step, input int lane, input int length);
        skew_t r;
        int    k;
        k     = step - lane - 1;
        r.vld = (k >= 0) && (k < length);
        r.k   = r.vld ? 32'(k) : '0;
        return r;
    endfunction

endpackage

// File: rtl/skew_lane_mux.sv
// One lane of the skewed operand stream: row LANE of A and column LANE of B, delayed by LANE steps.
// Latency: combinational from the feeder's registered step/operands.
// Backpressure: none; outputs are zero whenever feed_en is low or the lane is in its padding.
module skew_lane_mux
    import mmu_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LENGTH = DEF_LENGTH,
    parameter int LANE   = 0,
    parameter int STEP_W = 3
) (
    input  logic                          feed_en,
    input  logic [STEP_W-1:0]             step,
    input  logic [LENGTH-1:0][WIDTH-1:0]  a_row,      // A[LANE][*]
    input  logic [LENGTH-1:0][WIDTH-1:0]  b_col,      // B[*][LANE]
    output logic [WIDTH-1:0]              input_dat,
    output logic [WIDTH-1:0]              weight_dat
);

    skew_t sk;

    always_comb begin
        input_dat  = '0;
        weight_dat = '0;
        sk         = skew_idx(int'(step), LANE, LENGTH);
        // Compare against each index instead of indexing with sk.k directly,
        // which keeps the select width exact for any LENGTH.
        if (feed_en && sk.vld) begin
            for (int j = 0; j < LENGTH; j++) begin
                if (sk.k == 32'(j)) begin
                    input_dat  = a_row[j];
                    weight_dat = b_col[j];
                end
            end
        end
    end

endmodule

// File: rtl/systolic_operand_feeder.sv
// Latches A/B on Start&Ready, clears the MMU, streams skewed operands, drains, then pulses Done.
// Latency: Done is high in the 1+(2*LENGTH-1)+DRAIN_CYCLES+1'th cycle after the accepting edge.
// Backpressure: Ready only in IDLE; Start while Busy is ignored and operands stay frozen.
// Ports: CLK/ASYNC_RST (async active-low), Start/Ready handshake, MatrixA/MatrixB operands,
//        MmuSyncRst/MmuEn/Inputs/Weights to the MMU, Busy = ~Ready, Done one-cycle pulse.
module systolic_operand_feeder
    import mmu_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int LENGTH       = DEF_LENGTH,
    parameter int DRAIN_CYCLES = LENGTH
) (
    input  logic                                      CLK,
    input  logic                                      ASYNC_RST,
    input  logic                                      Start,
    output logic                                      Ready,
    input  logic [LENGTH-1:0][LENGTH-1:0][WIDTH-1:0]  MatrixA,
    input  logic [LENGTH-1:0][LENGTH-1:0][WIDTH-1:0]  MatrixB,
    output logic                                      MmuSyncRst,
    output logic                                      MmuEn,
    output logic [LENGTH-1:0][WIDTH-1:0]              Inputs,
    output logic [LENGTH-1:0][WIDTH-1:0]              Weights,
    output logic                                      Busy,
    output logic                                      Done
);

    localparam int STEP_W    = $clog2(2 * LENGTH);
    localparam int DRAIN_W   = $clog2(DRAIN_CYCLES + 1);
    localparam int LAST_STEP = 2 * LENGTH - 1;

    feeder_state_t                            state_q, state_d;
    logic [STEP_W-1:0]                        step_q, step_d;
    logic [DRAIN_W-1:0]                       drain_q, drain_d;
    logic [LENGTH-1:0][LENGTH-1:0][WIDTH-1:0] a_q, a_d;
    logic [LENGTH-1:0][LENGTH-1:0][WIDTH-1:0] b_q, b_d;
    logic                                     feeding;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        drain_d = drain_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE: begin
                // Operands are only captured here, so they cannot change mid-run.
                if (Start) begin
                    a_d     = MatrixA;
                    b_d     = MatrixB;
                    step_d  = STEP_W'(1);
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = FEED;
            end
            FEED: begin
                if (step_q == STEP_W'(LAST_STEP)) begin
                    step_d  = '0;
                    drain_d = '0;
                    state_d = DRAIN;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            DRAIN: begin
                // Zero operands keep EN high so the last products ripple to the far PEs.
                if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    drain_d = '0;
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state_q <= IDLE;
            step_q  <= '0;
            drain_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            drain_q <= drain_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Every output is a decode of registered state; Start never reaches an output directly.
    assign Ready      = (state_q == IDLE);
    assign Busy       = ~Ready;
    assign MmuSyncRst = (state_q == CLEAR);
    assign MmuEn      = (state_q == FEED) || (state_q == DRAIN);
    assign Done       = (state_q == DONE);
    assign feeding    = (state_q == FEED);

    for (genvar r = 0; r < LENGTH; r++) begin : g_lane
        logic [LENGTH-1:0][WIDTH-1:0] b_col;

        always_comb begin
            for (int k = 0; k < LENGTH; k++) begin
                b_col[k] = b_q[k][r];
            end
        end

        skew_lane_mux #(
            .WIDTH  (WIDTH),
            .LENGTH (LENGTH),
            .LANE   (r),
            .STEP_W (STEP_W)
        ) u_lane (
            .feed_en    (feeding),
            .step       (step_q),
            .a_row      (a_q[r]),
            .b_col      (b_col),
            .input_dat  (Inputs[r]),
            .weight_dat (Weights[r])
        );
    end

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Directed bench for systolic_operand_feeder with a behavioural MMU and a cycle-offset reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_systolic_operand_feeder;

    localparam int W       = 8;
    localparam int L       = 3;
    localparam int RUN_LEN = 1 + (2 * L - 1) + L + 1;   // cycles from accept to Done, inclusive

    typedef int mat_t [L][L];

    logic                          CLK = 1'b0;
    logic                          ASYNC_RST;
    logic                          Start;
    logic                          Ready, Busy, Done, MmuSyncRst, MmuEn;
    logic [L-1:0][L-1:0][W-1:0]    MatrixA, MatrixB;
    logic [L-1:0][W-1:0]           Inputs, Weights;

    systolic_operand_feeder #(.WIDTH(W), .LENGTH(L), .DRAIN_CYCLES(L)) dut (
        .CLK        (CLK),
        .ASYNC_RST  (ASYNC_RST),
        .Start      (Start),
        .Ready      (Ready),
        .MatrixA    (MatrixA),
        .MatrixB    (MatrixB),
        .MmuSyncRst (MmuSyncRst),
        .MmuEn      (MmuEn),
        .Inputs     (Inputs),
        .Weights    (Weights),
        .Busy       (Busy),
        .Done       (Done)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic mat_t mat_of(input logic [L-1:0][L-1:0][W-1:0] m);
        mat_t r;
        for (int i = 0; i < L; i++)
            for (int j = 0; j < L; j++)
                r[i][j] = int'(m[i][j]);
        return r;
    endfunction

    function automatic mat_t matmul(input mat_t a, input mat_t b);
        mat_t r;
        for (int i = 0; i < L; i++)
            for (int j = 0; j < L; j++) begin
                r[i][j] = 0;
                for (int k = 0; k < L; k++) r[i][j] += a[i][k] * b[k][j];
            end
        return r;
    endfunction

    mat_t A0   = '{'{4, 3, 7}, '{4, 4, 7}, '{6, 8, 2}};
    mat_t B0   = '{'{9, 4, 5}, '{10, 4, 5}, '{7, 4, 7}};
    mat_t ONES = '{'{1, 1, 1}, '{1, 1, 1}, '{1, 1, 1}};
    mat_t AB   = '{'{115, 56, 84}, '{125, 60, 89}, '{148, 64, 84}};
    mat_t BA   = '{'{82, 83, 101}, '{86, 86, 108}, '{86, 93, 91}};

    task automatic set_mats(input mat_t a, input mat_t b);
        for (int i = 0; i < L; i++)
            for (int j = 0; j < L; j++) begin
                MatrixA[i][j] = W'(a[i][j]);
                MatrixB[i][j] = W'(b[i][j]);
            end
    endtask

    // ---------------- behavioural output-stationary MMU ----------------
    int acc [L][L];
    int ar  [L][L];
    int wr  [L][L];

    always @(posedge CLK) begin
        int ain, win;
        for (int i = 0; i < L; i++)
            for (int j = 0; j < L; j++) begin
                if (MmuSyncRst) begin
                    acc[i][j] <= 0;
                    ar[i][j]  <= 0;
                    wr[i][j]  <= 0;
                end else if (MmuEn) begin
                    if (j == 0) ain = int'(Inputs[i]);
                    else        ain = ar[i][j-1];
                    if (i == 0) win = int'(Weights[j]);
                    else        win = wr[i-1][j];
                    acc[i][j] <= acc[i][j] + ain * win;
                    ar[i][j]  <= ain;
                    wr[i][j]  <= win;
                end
            end
    end

    // ---------------- reference model: cycle offset since acceptance ----------------
    // m_t == 0 means idle; 1..RUN_LEN numbers the cycles after the accepting edge.
    int   m_t = 0;
    mat_t m_a, m_b;

    always @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            m_t <= 0;
        end else if (m_t == 0) begin
            if (Start) begin
                m_t <= 1;
                m_a <= mat_of(MatrixA);
                m_b <= mat_of(MatrixB);
            end
        end else if (m_t == RUN_LEN) begin
            m_t <= 0;
        end else begin
            m_t <= m_t + 1;
        end
    end

    int snap_in [2*L][L];
    int snap_w  [2*L][L];
    int en_cnt   = 0;
    int sync_cnt = 0;
    int done_cnt = 0;

    always @(negedge CLK) begin
        logic [4:0] e;
        int s, k, ei, ew;
        e = {m_t == 0, m_t != 0, m_t == 1, (m_t >= 2) && (m_t < RUN_LEN), m_t == RUN_LEN};
        chk("ctrl{rdy,busy,srst,en,done}", {Ready, Busy, MmuSyncRst, MmuEn, Done}, e);
        s = m_t - 1;
        for (int r = 0; r < L; r++) begin
            k  = s - r - 1;
            ei = 0;
            ew = 0;
            if (m_t >= 2 && m_t <= 2 * L && k >= 0 && k < L) begin
                ei = m_a[r][k];
                ew = m_b[k][r];
            end
            chk($sformatf("inputs[%0d]", r), Inputs[r], ei);
            chk($sformatf("weights[%0d]", r), Weights[r], ew);
            if (m_t >= 2 && m_t <= 2 * L) begin
                snap_in[s][r] = int'(Inputs[r]);
                snap_w[s][r]  = int'(Weights[r]);
            end
        end
        en_cnt   += int'(MmuEn);
        sync_cnt += int'(MmuSyncRst);
        done_cnt += int'(Done);
    end

    // ---------------- directed scenarios ----------------
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!Done && lat < 40);
        chk("done_seen", Done, 1);
    endtask

    task automatic chk_res(input string name, input mat_t exp);
        for (int i = 0; i < L; i++)
            for (int j = 0; j < L; j++)
                chk($sformatf("%s[%0d][%0d]", name, i, j), acc[i][j], exp[i][j]);
    endtask

    int step_ids [3] = '{1, 3, 5};
    mat_t exp_in = '{'{4, 0, 0}, '{7, 4, 6}, '{0, 0, 2}};
    mat_t exp_w  = '{'{9, 0, 0}, '{7, 4, 5}, '{0, 0, 7}};

    initial begin
        int lat, done_before;
        ASYNC_RST = 1'b0;
        Start     = 1'b0;
        set_mats(A0, B0);
        repeat (2) @(posedge CLK);
        #1 ASYNC_RST = 1'b1;

        // 1: reset state, handshake, latency
        @(negedge CLK);
        chk("reset_ready", Ready, 1);
        chk("reset_outs", {Done, MmuEn, MmuSyncRst, Inputs, Weights}, 0);
        @(posedge CLK);
        #1 Start = 1'b1;
        en_cnt = 0;
        @(posedge CLK);
        #1 Start = 1'b0;
        chk("ready_fell", Ready, 0);
        chk("clear_first", MmuSyncRst, 1);
        wait_done(lat);
        chk("latency", lat, RUN_LEN);

        // 2: skew literals and EN length
        for (int n = 0; n < 3; n++)
            for (int r = 0; r < L; r++) begin
                chk($sformatf("step%0d_in[%0d]", step_ids[n], r), snap_in[step_ids[n]][r], exp_in[n][r]);
                chk($sformatf("step%0d_w[%0d]", step_ids[n], r), snap_w[step_ids[n]][r], exp_w[n][r]);
            end
        chk("en_cycles", en_cnt, 8);

        // 3: product through the MMU
        chk_res("res_ab", AB);
        chk_res("model_ab", matmul(A0, B0));

        // 4: Start held while busy, A changed mid-run
        @(posedge CLK);
        #1 Start = 1'b1;
        repeat (3) @(posedge CLK);
        #1 set_mats(ONES, B0);
        wait_done(lat);
        chk_res("res_held", AB);
        @(negedge CLK);
        chk("idle_after_done", Ready, 1);
        @(negedge CLK);
        chk("rerun_clear", MmuSyncRst, 1);
        Start = 1'b0;
        wait_done(lat);
        chk_res("res_ones", matmul(ONES, B0));
        set_mats(A0, B0);

        // 5: reset during FEED step 3
        @(posedge CLK);
        #1 Start = 1'b1;
        @(posedge CLK);
        #1 Start = 1'b0;
        repeat (3) @(posedge CLK);
        #1 chk("step3_en", MmuEn, 1);
        ASYNC_RST = 1'b0;
        #1;
        chk("abort_ctrl", {Ready, Busy, MmuSyncRst, MmuEn, Done}, 5'b10000);
        chk("abort_ops", {Inputs, Weights}, 0);
        done_before = done_cnt;
        repeat (2) @(posedge CLK);
        #1 ASYNC_RST = 1'b1;
        repeat (15) @(negedge CLK);
        chk("no_done_after_abort", done_cnt, done_before);
        @(posedge CLK);
        #1 Start = 1'b1;
        @(posedge CLK);
        #1 Start = 1'b0;
        wait_done(lat);
        chk_res("res_after_abort", AB);

        // 6: back-to-back with swapped operands on the second run
        @(posedge CLK);
        #1 Start = 1'b1;
        sync_cnt = 0;
        @(posedge CLK);
        #1 set_mats(B0, A0);
        wait_done(lat);
        chk_res("res_b2b_first", AB);
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!MmuSyncRst && lat < 10);
        chk("b2b_second_clear", MmuSyncRst, 1);
        Start = 1'b0;
        wait_done(lat);
        chk_res("res_ba", BA);
        chk_res("model_ba", matmul(B0, A0));
        chk("b2b_clear_count", sync_cnt, 2);

        repeat (2) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
